// File: rtl/sprite_row_fetch_scheduler_if.sv
// sprite_row_fetch_scheduler_if: sprite-memory read port and line-buffer write port
interface sprite_row_fetch_scheduler_if;
  logic        o_Mem_Read_En;
  logic [10:0] o_Mem_Read_Addr;
  logic [8:0]  i_Mem_Read_Data;
  logic        o_Lb_Write_En;
  logic [8:0]  o_Lb_Write_Addr;
  logic [8:0]  o_Lb_Write_Data;
  modport master (
    output o_Mem_Read_En, o_Mem_Read_Addr,
    input  i_Mem_Read_Data,
    output o_Lb_Write_En, o_Lb_Write_Addr, o_Lb_Write_Data
  );
  modport slave (
    input  o_Mem_Read_En, o_Mem_Read_Addr,
    output i_Mem_Read_Data,
    input  o_Lb_Write_En, o_Lb_Write_Addr, o_Lb_Write_Data
  );
endinterface

// File: rtl/sprite_row_fetch_scheduler.sv
// sprite_row_fetch_scheduler: fetches hit sprite rows one scanline ahead into a double-buffered line buffer
module sprite_row_fetch_scheduler #(
  parameter int TILE_SIZE   = 32,
  parameter int NUM_SLOTS   = 5,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Line_Start,
  input  logic [9:0]               i_Next_Line,
  input  logic [10*NUM_SLOTS-1:0]  i_Sprite_X,
  input  logic [10*NUM_SLOTS-1:0]  i_Sprite_Y,
  input  logic [NUM_SLOTS-1:0]     i_Sprite_En,
  input  logic [NUM_SLOTS-1:0]     i_Slot_Table,
  sprite_row_fetch_scheduler_if.master bus,
  output logic                     o_Lb_Bank,
  output logic [NUM_SLOTS-1:0]     o_Slot_Valid,
  output logic [10*NUM_SLOTS-1:0]  o_Slot_X,
  output logic                     o_Busy,
  output logic                     o_Overrun
);
  localparam int CW = $clog2(TILE_SIZE);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t                    r_state, w_state_nx;
  logic [10*NUM_SLOTS-1:0]   r_x, r_slot_x;
  logic [NUM_SLOTS-1:0]      r_tab, r_hit, r_slot_valid, w_hit;
  logic [CW-1:0]             r_row [NUM_SLOTS];
  logic [CW-1:0]             w_row [NUM_SLOTS];
  logic [2:0]                r_slot, w_first, w_next;
  logic [CW-1:0]             r_col;
  logic                      r_bank, r_overrun, w_more, w_last, w_accept, w_rd, w_pend;
  logic [MEM_LATENCY-1:0]    r_pv, w_pv_sh;
  logic [2:0]                r_ps [MEM_LATENCY];
  logic [CW-1:0]             r_pc [MEM_LATENCY];
  assign w_accept = i_Line_Start && r_state == IDLE;
  assign w_rd     = r_state == FETCH;
  assign w_last   = r_col == CW'(TILE_SIZE - 1);
  assign w_pv_sh  = r_pv << 1;
  assign w_pend   = |w_pv_sh;
  // Hit test uses an 11-bit upper bound so sprites near Y=1023 do not wrap
  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_hit[k] = i_Sprite_En[k]
              && ({1'b0, i_Next_Line} >= {1'b0, i_Sprite_Y[10*k +: 10]})
              && ({1'b0, i_Next_Line} < {1'b0, i_Sprite_Y[10*k +: 10]} + 11'(TILE_SIZE));
      w_row[k] = CW'(i_Next_Line - i_Sprite_Y[10*k +: 10]);
    end
  end
  // Priority encoders: lowest fresh hit, and next snapshot hit above the current slot
  always_comb begin
    w_first = '0;
    w_next  = '0;
    w_more  = 1'b0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (w_hit[k]) w_first = 3'(k);
      if (r_hit[k] && 3'(k) > r_slot) begin
        w_next = 3'(k);
        w_more = 1'b1;
      end
    end
  end
  // State register
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) r_state <= IDLE;
    else         r_state <= w_state_nx;
  // Next-state logic; DRAIN leaves once only the in-flight write of this cycle remains
  always_comb begin
    w_state_nx = r_state == IDLE  ? (i_Line_Start ? (|w_hit ? FETCH : DRAIN) : IDLE)
               : r_state == FETCH ? ((w_last && !w_more) ? DRAIN : FETCH)
               : (w_pend ? DRAIN : IDLE);
  end
  // FSM outputs: read strobe/address during FETCH, busy outside IDLE
  always_comb begin
    o_Busy              = r_state != IDLE;
    bus.o_Mem_Read_En   = w_rd;
    bus.o_Mem_Read_Addr = w_rd ? {r_tab[r_slot], 10'({r_row[r_slot], r_col})} : '0;
  end
  // Snapshot on accepted line start, then walk slot/column through the fetch
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      r_x          <= '0;
      r_tab        <= '0;
      r_hit        <= '0;
      r_slot_valid <= '0;
      r_slot_x     <= '0;
      r_bank       <= 1'b0;
      r_slot       <= '0;
      r_col        <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) r_row[k] <= '0;
    end else if (w_accept) begin
      r_x          <= i_Sprite_X;
      r_tab        <= i_Slot_Table;
      r_hit        <= w_hit;
      r_slot_valid <= r_hit;
      r_slot_x     <= r_x;
      r_bank       <= ~r_bank;
      r_slot       <= w_first;
      r_col        <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) r_row[k] <= w_row[k];
    end else if (w_rd) begin
      r_col <= r_col + CW'(1);
      if (w_last) r_slot <= w_next;
    end
  // Tag pipeline: {slot, col} travels alongside each read until its data returns
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      r_pv <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_ps[i] <= '0;
        r_pc[i] <= '0;
      end
    end else begin
      r_pv    <= w_pv_sh | MEM_LATENCY'(w_rd);
      r_ps[0] <= r_slot;
      r_pc[0] <= r_col;
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        r_ps[i] <= r_ps[i-1];
        r_pc[i] <= r_pc[i-1];
      end
    end
  // Sticky overrun on any line start that cannot be accepted
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) r_overrun <= 1'b0;
    else if (i_Line_Start && r_state != IDLE) r_overrun <= 1'b1;
  assign bus.o_Lb_Write_En   = r_pv[MEM_LATENCY-1];
  assign bus.o_Lb_Write_Addr = r_pv[MEM_LATENCY-1] ? {r_bank, r_ps[MEM_LATENCY-1], r_pc[MEM_LATENCY-1]} : '0;
  assign bus.o_Lb_Write_Data = r_pv[MEM_LATENCY-1] ? bus.i_Mem_Read_Data : '0;
  assign o_Lb_Bank    = r_bank;
  assign o_Slot_Valid = r_slot_valid;
  assign o_Slot_X     = r_slot_x;
  assign o_Overrun    = r_overrun;
endmodule
